// File: rtl/wakeup_dependency_matrix.sv
// wakeup_dependency_matrix: IQ producer matrix tracking per-entry wakeup dependencies; WAKEUP_DEP_MATRIX_OLDEST_EN adds age-based oldest-ready select
module wakeup_dependency_matrix #(
  parameter int ENTRY_NUM = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int WAKEUP_WIDTH = 4,
  localparam int PTR_W = $clog2(ENTRY_NUM)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [DISPATCH_WIDTH-1:0]                    dispatch,
  input  logic [DISPATCH_WIDTH-1:0][PTR_W-1:0]         dispatchPtr,
  input  logic [DISPATCH_WIDTH-1:0][ENTRY_NUM-1:0]     dispatchDepVector,
  input  logic [WAKEUP_WIDTH-1:0]                      wakeup,
  input  logic [WAKEUP_WIDTH-1:0][ENTRY_NUM-1:0]       wakeupVector,
  input  logic [WAKEUP_WIDTH-1:0]                      releaseEntry,
  input  logic [WAKEUP_WIDTH-1:0][PTR_W-1:0]           releasePtr,
  input  logic [ENTRY_NUM-1:0]                         flushIQ_Entry,
  output logic [ENTRY_NUM-1:0]                         entryValid,
  output logic [ENTRY_NUM-1:0]                         entryReady,
  output logic [PTR_W:0]                               freeCount,
  output logic                                         dispatchConflict
`ifdef WAKEUP_DEP_MATRIX_OLDEST_EN
  ,
  output logic                                         oldestReadyValid,
  output logic [PTR_W-1:0]                             oldestReadyPtr
`endif
);
  logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] dep_q, dep_d, disp_row;
  logic [ENTRY_NUM-1:0] valid_d, ready_d, wake_mask, disp_hit, rel_hit;
  logic conflict_d;
  logic [PTR_W:0] free_d;
  always_comb begin
    wake_mask = '0;
    disp_hit = '0;
    rel_hit = '0;
    disp_row = '0;
    conflict_d = dispatchConflict;
    free_d = (PTR_W+1)'(ENTRY_NUM);
    for (int w = 0; w < WAKEUP_WIDTH; w++) begin
      wake_mask = wake_mask | (wakeup[w] ? wakeupVector[w] : '0);
      if (releaseEntry[w]) rel_hit[releasePtr[w]] = 1'b1;
    end
    // later slots overwrite earlier ones, so slot 1 wins a shared pointer
    for (int d = 0; d < DISPATCH_WIDTH; d++) begin
      if (dispatch[d]) begin
        disp_hit[dispatchPtr[d]] = 1'b1;
        disp_row[dispatchPtr[d]] = dispatchDepVector[d] & ~wake_mask;
        if (entryValid[dispatchPtr[d]] && !rel_hit[dispatchPtr[d]] && !flushIQ_Entry[dispatchPtr[d]]) conflict_d = 1'b1;
        for (int e = 0; e < d; e++)
          if (dispatch[e] && dispatchPtr[e] == dispatchPtr[d]) conflict_d = 1'b1;
      end
    end
    for (int i = 0; i < ENTRY_NUM; i++) begin
      valid_d[i] = disp_hit[i] | (entryValid[i] & ~flushIQ_Entry[i] & ~rel_hit[i]);
      dep_d[i] = disp_hit[i] ? disp_row[i] : dep_q[i] & ~wake_mask & ~disp_hit;
      ready_d[i] = valid_d[i] & ~|dep_d[i];
      free_d = free_d - (PTR_W+1)'(valid_d[i]);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dep_q <= '0;
      entryValid <= '0;
      entryReady <= '0;
      freeCount <= (PTR_W+1)'(ENTRY_NUM);
      dispatchConflict <= 1'b0;
    end else begin
      dep_q <= dep_d;
      entryValid <= valid_d;
      entryReady <= ready_d;
      freeCount <= free_d;
      dispatchConflict <= conflict_d;
    end
  end
`ifdef WAKEUP_DEP_MATRIX_OLDEST_EN
  logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] age_q, age_d;
  logic [ENTRY_NUM-1:0] older_slot, blocked;
  logic [PTR_W-1:0] oldest_ptr_d;
  always_comb begin
    age_d = age_q;
    older_slot = '0;
    blocked = '0;
    oldest_ptr_d = '0;
    // age[j][k]=1: j is older than k; a new entry is younger than everything live
    for (int d = 0; d < DISPATCH_WIDTH; d++) begin
      if (dispatch[d]) begin
        age_d[dispatchPtr[d]] = '0;
        for (int j = 0; j < ENTRY_NUM; j++)
          if (PTR_W'(j) != dispatchPtr[d] && (entryValid[j] || older_slot[j])) age_d[j][dispatchPtr[d]] = 1'b1;
        older_slot[dispatchPtr[d]] = 1'b1;
      end
    end
    for (int i = 0; i < ENTRY_NUM; i++)
      for (int j = 0; j < ENTRY_NUM; j++)
        blocked[i] = blocked[i] | (ready_d[j] & age_d[j][i]);
    for (int i = 0; i < ENTRY_NUM; i++)
      if (ready_d[i] && !blocked[i]) oldest_ptr_d = PTR_W'(i);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_q <= '0;
      oldestReadyValid <= 1'b0;
      oldestReadyPtr <= '0;
    end else begin
      age_q <= age_d;
      oldestReadyValid <= |ready_d;
      oldestReadyPtr <= oldest_ptr_d;
    end
  end
`endif
endmodule

// File: tb/tb_wakeup_dependency_matrix.sv
// tb_wakeup_dependency_matrix: directed and randomized checks against a set-based reference model
module tb_wakeup_dependency_matrix;
  localparam int E = 16;
  localparam int D = 2;
  localparam int W = 4;
  localparam int P = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [D-1:0] dispatch;
  logic [D-1:0][P-1:0] dispatchPtr;
  logic [D-1:0][E-1:0] dispatchDepVector;
  logic [W-1:0] wakeup;
  logic [W-1:0][E-1:0] wakeupVector;
  logic [W-1:0] releaseEntry;
  logic [W-1:0][P-1:0] releasePtr;
  logic [E-1:0] flushIQ_Entry;
  logic [E-1:0] entryValid, entryReady;
  logic [P:0] freeCount;
  logic dispatchConflict;
`ifdef WAKEUP_DEP_MATRIX_OLDEST_EN
  logic oldestReadyValid;
  logic [P-1:0] oldestReadyPtr;
`endif
  always #5 clk = ~clk;
  wakeup_dependency_matrix #(.ENTRY_NUM(E), .DISPATCH_WIDTH(D), .WAKEUP_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .dispatch(dispatch), .dispatchPtr(dispatchPtr),
    .dispatchDepVector(dispatchDepVector), .wakeup(wakeup), .wakeupVector(wakeupVector),
    .releaseEntry(releaseEntry), .releasePtr(releasePtr), .flushIQ_Entry(flushIQ_Entry),
    .entryValid(entryValid), .entryReady(entryReady), .freeCount(freeCount),
    .dispatchConflict(dispatchConflict)
`ifdef WAKEUP_DEP_MATRIX_OLDEST_EN
    , .oldestReadyValid(oldestReadyValid), .oldestReadyPtr(oldestReadyPtr)
`endif
  );
  // model: per entry a live flag, a set of pending producers and a dispatch sequence number
  bit m_valid[E];
  bit [E-1:0] m_dep[E];
  int m_seq[E];
  int seq_ctr = 0;
  bit m_conf;
  int n_pass = 0;
  int n_checks = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask
  function automatic void model_reset();
    for (int i = 0; i < E; i++) begin
      m_valid[i] = 0;
      m_dep[i] = '0;
      m_seq[i] = 0;
    end
    m_conf = 0;
  endfunction
  function automatic void model_step();
    bit [E-1:0] woken = '0;
    bit freed[E];
    int p;
    for (int w = 0; w < W; w++) if (wakeup[w]) woken |= wakeupVector[w];
    for (int i = 0; i < E; i++) begin
      freed[i] = flushIQ_Entry[i];
      m_dep[i] &= ~woken;
    end
    for (int w = 0; w < W; w++) if (releaseEntry[w]) freed[int'(releasePtr[w])] = 1;
    for (int d = 0; d < D; d++) if (dispatch[d]) begin
      p = int'(dispatchPtr[d]);
      if (m_valid[p] && !freed[p]) m_conf = 1;
      for (int i = 0; i < E; i++) if (i != p) m_dep[i][p] = 0;
    end
    if (dispatch[0] && dispatch[1] && dispatchPtr[0] == dispatchPtr[1]) m_conf = 1;
    for (int i = 0; i < E; i++) if (freed[i]) m_valid[i] = 0;
    for (int d = 0; d < D; d++) if (dispatch[d]) begin
      p = int'(dispatchPtr[d]);
      m_valid[p] = 1;
      m_dep[p] = dispatchDepVector[d] & ~woken;
      m_seq[p] = seq_ctr++;
    end
  endfunction
  function automatic logic [31:0] exp_valid();
    logic [31:0] r = '0;
    for (int i = 0; i < E; i++) r[i] = m_valid[i];
    return r;
  endfunction
  function automatic logic [31:0] exp_ready();
    logic [31:0] r = '0;
    for (int i = 0; i < E; i++) r[i] = m_valid[i] && m_dep[i] == '0;
    return r;
  endfunction
  function automatic logic [31:0] exp_free();
    int n = E;
    for (int i = 0; i < E; i++) n -= int'(m_valid[i]);
    return 32'(n);
  endfunction
  function automatic int exp_oldest();
    int best = -1;
    for (int i = 0; i < E; i++)
      if (m_valid[i] && m_dep[i] == '0 && (best < 0 || m_seq[i] < m_seq[best])) best = i;
    return best;
  endfunction
  task automatic check_all();
    check("entryValid", 32'(entryValid), exp_valid());
    check("entryReady", 32'(entryReady), exp_ready());
    check("freeCount", 32'(freeCount), exp_free());
    check("dispatchConflict", 32'(dispatchConflict), 32'(m_conf));
`ifdef WAKEUP_DEP_MATRIX_OLDEST_EN
    check("oldestReadyValid", 32'(oldestReadyValid), 32'(exp_oldest() >= 0));
    if (exp_oldest() >= 0) check("oldestReadyPtr", 32'(oldestReadyPtr), 32'(exp_oldest()));
`endif
  endtask
  task automatic idle_inputs();
    dispatch = '0;
    dispatchPtr = '0;
    dispatchDepVector = '0;
    wakeup = '0;
    wakeupVector = '0;
    releaseEntry = '0;
    releasePtr = '0;
    flushIQ_Entry = '0;
  endtask
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    idle_inputs();
  endtask
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_freeCount", 32'(freeCount), 32'd16);
    check("rst_entryValid", 32'(entryValid), 32'd0);
    check("rst_conflict", 32'(dispatchConflict), 32'd0);
`ifdef WAKEUP_DEP_MATRIX_OLDEST_EN
    check("rst_oldestValid", 32'(oldestReadyValid), 32'd0);
    check("rst_oldestPtr", 32'(oldestReadyPtr), 32'd0);
`endif
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic disp(input int slot, input int ptr, input logic [E-1:0] dep);
    dispatch[slot] = 1'b1;
    dispatchPtr[slot] = P'(ptr);
    dispatchDepVector[slot] = dep;
  endtask
  function automatic int pick_ptr();
    int q[$];
    for (int i = 0; i < E; i++) if (!m_valid[i]) q.push_back(i);
    if (q.size() == 0 || $urandom_range(0, 3) == 0) return int'($urandom_range(0, E - 1));
    return q[$urandom_range(0, q.size() - 1)];
  endfunction
  initial begin
    idle_inputs();
    model_reset();
    #1 rst = 1'b0;
    #7;
    check("reset_state", {entryValid, entryReady}, 32'd0);
    check("reset_free", 32'(freeCount), 32'd16);
    check("reset_conflict", 32'(dispatchConflict), 32'd0);
    #4 rst = 1'b1;
    disp(0, 3, '0);
    step();
    check("t1_valid3", 32'(entryValid[3]), 32'd1);
    check("t1_ready3", 32'(entryReady[3]), 32'd1);
    check("t1_free", 32'(freeCount), 32'd15);
    disp(0, 5, E'(1) << 3);
    step();
    check("t2_ready5_a", 32'(entryReady[5]), 32'd0);
    step();
    check("t2_ready5_b", 32'(entryReady[5]), 32'd0);
    wakeup[2] = 1'b1;
    wakeupVector[2] = E'(1) << 3;
    step();
    check("t2_ready5_c", 32'(entryReady[5]), 32'd1);
    disp(1, 6, E'(1) << 2);
    wakeup[0] = 1'b1;
    wakeupVector[0] = E'(1) << 2;
    step();
    check("t3_ready6", 32'(entryReady[6]), 32'd1);
    releaseEntry[1] = 1'b1;
    releasePtr[1] = P'(3);
    disp(0, 3, '0);
    step();
    check("t4_valid3", 32'(entryValid[3]), 32'd1);
    check("t4_noconflict", 32'(dispatchConflict), 32'd0);
    disp(0, 5, '0);
    step();
    check("t4_conflict", 32'(dispatchConflict), 32'd1);
    step();
    check("t4_sticky", 32'(dispatchConflict), 32'd1);
    async_reset();
    for (int c = 0; c < 8; c++) begin
      disp(0, 2 * c, '0);
      disp(1, 2 * c + 1, '0);
      step();
    end
    check("t5_full", 32'(freeCount), 32'd0);
    flushIQ_Entry = 16'h00F0;
    step();
    check("t5_flush", 32'(freeCount), 32'd4);
    disp(0, 4, '0);
    step();
    async_reset();
`ifdef WAKEUP_DEP_MATRIX_OLDEST_EN
    disp(0, 7, '0);
    step();
    disp(0, 2, '0);
    step();
    disp(0, 9, '0);
    disp(1, 1, '0);
    step();
    check("t6_oldest7", 32'(oldestReadyPtr), 32'd7);
    releaseEntry[0] = 1'b1;
    releasePtr[0] = P'(7);
    step();
    check("t6_oldest2", 32'(oldestReadyPtr), 32'd2);
    async_reset();
`endif
    for (int c = 0; c < 400; c++) begin
      if (c == 200) async_reset();
      for (int d = 0; d < D; d++) begin
        dispatch[d] = 1'($urandom_range(0, 1));
        dispatchPtr[d] = P'(pick_ptr());
        dispatchDepVector[d] = E'($urandom) & E'($urandom) & E'($urandom);
      end
      for (int w = 0; w < W; w++) begin
        wakeup[w] = 1'($urandom_range(0, 1));
        wakeupVector[w] = E'(1) << $urandom_range(0, E - 1);
        releaseEntry[w] = ($urandom_range(0, 3) == 0);
        releasePtr[w] = P'($urandom_range(0, E - 1));
      end
      flushIQ_Entry = ($urandom_range(0, 15) == 0) ? E'($urandom) : '0;
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
